// File: rtl/link_sync_ctrl.sv
// Link training and byte-stream sequencing for the PHY TX/RX serializer pair.
// Latency: one clk_4f cycle from accepted payload to tx_byte, and from rx_byte to data_out.
// Backpressure: ready_out drops outside ACTIVE, on COM-insertion cycles and while reset is held.
//
// Ports:
//   clk_4f, reset         byte clock; synchronous active-high reset
//   rx_byte/rx_byte_valid aligned byte from the serial-to-parallel RX
//   data_in/valid_in      upstream payload offer; accepted when valid_in && ready_out
//   ready_out             combinational accept strobe
//   tx_byte               byte driven to the parallel-to-serial TX
//   active                link locked
//   idle_out              tx_byte currently carries IDL
//   data_out/valid_out    filtered received payload, one-cycle valid pulse per byte
//   err_out               one-cycle pulse when upstream offered COM or IDL as payload
module link_sync_ctrl #(
    parameter logic [7:0]  COM         = 8'hBC,
    parameter logic [7:0]  IDL         = 8'h7C,
    parameter int unsigned N_LOCK      = 4,
    parameter int unsigned N_LOSS      = 3,
    parameter int unsigned SKIP_PERIOD = 16
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_valid,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [7:0] tx_byte,
    output logic       active,
    output logic       idle_out,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       err_out
);

    localparam int LOCK_W = $clog2(N_LOCK + 1);
    localparam int LOSS_W = $clog2(N_LOSS + 1);
    localparam int SKIP_W = $clog2(SKIP_PERIOD);

    // Terminal values: reaching the counter's maximum is detected one step early
    // so the transition happens on the same edge the count would hit it.
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(N_LOCK - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(N_LOSS - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_PERIOD - 1);

    typedef enum logic {
        TRAIN  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LOCK_W-1:0] lock_cnt, lock_d;
    logic [LOSS_W-1:0] loss_cnt, loss_d;
    logic [SKIP_W-1:0] skip_cnt, skip_d;
    logic [7:0]        tx_d;
    logic [7:0]        data_d;
    logic              active_d;
    logic              idle_d;
    logic              vout_d;
    logic              err_d;

    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == COM) || (b == IDL);
    endfunction

    // Reset is folded in so upstream never sees an accept on an edge that
    // will be discarded by reset.
    assign ready_out = active && (skip_cnt != SKIP_LAST) && !reset;

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_cnt;
        loss_d   = loss_cnt;
        skip_d   = skip_cnt;
        tx_d     = tx_byte;
        data_d   = data_out;
        active_d = active;
        idle_d   = idle_out;
        vout_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            TRAIN: begin
                tx_d   = COM;
                idle_d = 1'b0;
                loss_d = '0;
                skip_d = '0;
                if (rx_byte_valid && (rx_byte == COM)) begin
                    if (lock_cnt == LOCK_LAST) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                        lock_d   = '0;
                    end else begin
                        lock_d = lock_cnt + 1'b1;
                    end
                end else begin
                    lock_d = '0;
                end
            end

            ACTIVE: begin
                if (!rx_byte_valid && (loss_cnt == LOSS_LAST)) begin
                    // Loss overrides skip insertion and payload: the offered
                    // byte is not consumed and must be re-offered after relock.
                    state_d  = TRAIN;
                    active_d = 1'b0;
                    lock_d   = '0;
                    loss_d   = '0;
                    skip_d   = '0;
                    tx_d     = COM;
                    idle_d   = 1'b0;
                end else begin
                    loss_d = rx_byte_valid ? '0 : loss_cnt + 1'b1;

                    if (rx_byte_valid && !is_ctrl(rx_byte)) begin
                        data_d = rx_byte;
                        vout_d = 1'b1;
                    end

                    if (skip_cnt == SKIP_LAST) begin
                        tx_d   = COM;
                        idle_d = 1'b0;
                        skip_d = '0;
                    end else begin
                        skip_d = skip_cnt + 1'b1;
                        if (valid_in && !is_ctrl(data_in)) begin
                            tx_d   = data_in;
                            idle_d = 1'b0;
                        end else begin
                            // A control symbol offered as payload is swallowed
                            // and flagged; the line idles that cycle.
                            tx_d   = IDL;
                            idle_d = 1'b1;
                            err_d  = valid_in;
                        end
                    end
                end
            end

            default: begin
                state_d = TRAIN;
            end
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q   <= TRAIN;
            lock_cnt  <= '0;
            loss_cnt  <= '0;
            skip_cnt  <= '0;
            tx_byte   <= 8'h00;
            active    <= 1'b0;
            idle_out  <= 1'b0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_cnt  <= lock_d;
            loss_cnt  <= loss_d;
            skip_cnt  <= skip_d;
            tx_byte   <= tx_d;
            active    <= active_d;
            idle_out  <= idle_d;
            data_out  <= data_d;
            valid_out <= vout_d;
            err_out   <= err_d;
        end
    end

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Scoreboard bench for link_sync_ctrl: stimulus pushes expected payload bytes,
// a negedge monitor pops them as the DUT presents tx payload or valid_out.
// Cycle-level control behaviour is checked directly against hand-computed values.
module tb_link_sync_ctrl;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    logic       clk_4f;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic [7:0] tx_byte;
    logic       active;
    logic       idle_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       err_out;

    link_sync_ctrl dut (
        .clk_4f        (clk_4f),
        .reset         (reset),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .tx_byte       (tx_byte),
        .active        (active),
        .idle_out      (idle_out),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .err_out       (err_out)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    int         checks = 0;
    int         errors = 0;
    int         pos    = 0;     // index of the current ACTIVE cycle since lock
    logic       mon_en = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == COM) || (b == IDL);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk_4f);
    endtask

    // Monitor: every payload byte seen on tx_byte or data_out must match the
    // next expected entry, in order.
    always @(negedge clk_4f) begin
        if (mon_en) begin
            if (tx_byte !== 8'h00 && tx_byte !== COM && tx_byte !== IDL) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got=%0h expected=none at t=%0t", tx_byte, $time);
                end else begin
                    chk("tx_payload", tx_byte, tx_q.pop_front());
                end
            end
            if (valid_out !== 1'b0) begin
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got=%0h expected=none at t=%0t", data_out, $time);
                end else begin
                    chk("rx_payload", data_out, rx_q.pop_front());
                end
            end
        end
    end

    // One ACTIVE cycle without loss: ready_out follows the bench's own skip
    // position, and the TX symbol after the edge is checked by category.
    task automatic act_cycle(input logic off, input logic [7:0] d, input logic rv,
                             input logic [7:0] rb, output logic acc);
        logic exp_rdy;
        valid_in      = off;
        data_in       = d;
        rx_byte_valid = rv;
        rx_byte       = rb;
        exp_rdy       = (pos % 16) != 15;
        chk("ready_out", ready_out, exp_rdy);
        acc = off && exp_rdy;
        if (acc && !is_ctrl(d)) tx_q.push_back(d);
        if (rv && !is_ctrl(rb)) rx_q.push_back(rb);
        cyc();
        chk("active_hold", active, 1);
        chk("err_out", err_out, acc && is_ctrl(d));
        if (!exp_rdy) begin
            chk("skip_com", tx_byte, COM);
            chk("skip_idle", idle_out, 0);
        end else if (!(off && !is_ctrl(d))) begin
            chk("idle_tx", tx_byte, IDL);
            chk("idle_flag", idle_out, 1);
        end else begin
            chk("payload_idle", idle_out, 0);
        end
        pos++;
    endtask

    task automatic lock4();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_byte_valid = 1'b1;
            rx_byte       = COM;
            chk("train_ready", ready_out, 0);
            cyc();
            chk("relock_active", active, i == 3);
            chk("relock_tx", tx_byte, COM);
        end
        rx_byte = IDL;
        pos     = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       acc;
        logic [7:0] nd;
        logic [7:0] pat [8];
        pat = '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};

        reset         = 1'b1;
        rx_byte_valid = 1'b0;
        rx_byte       = 8'h00;
        valid_in      = 1'b0;
        data_in       = 8'h00;

        // Reset held two cycles.
        cyc();
        mon_en = 1'b1;
        cyc();
        chk("rst_tx", tx_byte, 8'h00);
        chk("rst_active", active, 0);
        chk("rst_ready", ready_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_idle", idle_out, 0);
        chk("rst_data_out", data_out, 8'h00);

        reset = 1'b0;
        cyc();
        chk("first_tx", tx_byte, COM);
        chk("first_active", active, 0);
        chk("first_ready", ready_out, 0);

        // Interrupted COM run: lock only after the final four.
        for (int k = 0; k < 8; k++) begin
            rx_byte_valid = 1'b1;
            rx_byte       = pat[k];
            chk("train_ready", ready_out, 0);
            cyc();
            chk("lock_active", active, k == 7);
            chk("lock_tx", tx_byte, COM);
        end
        pos = 0;

        // Payload, idle, RX filter and control-symbol errors.
        act_cycle(1'b1, 8'hA5, 1'b1, 8'h12, acc);
        chk("rx_valid_pulse", valid_out, 1);
        chk("rx_data", data_out, 8'h12);
        act_cycle(1'b1, 8'h3C, 1'b1, IDL, acc);
        chk("rx_valid_drop", valid_out, 0);
        chk("rx_data_hold", data_out, 8'h12);
        act_cycle(1'b0, 8'h00, 1'b1, IDL, acc);
        act_cycle(1'b1, COM, 1'b1, IDL, acc);
        act_cycle(1'b0, 8'h00, 1'b1, IDL, acc);
        act_cycle(1'b1, IDL, 1'b1, IDL, acc);
        act_cycle(1'b0, 8'h00, 1'b1, IDL, acc);

        // Continuous stream across two COM insertions; refused bytes are re-offered.
        nd = 8'h20;
        for (int k = 0; k < 34; k++) begin
            act_cycle(1'b1, nd, 1'b1, (k % 2 == 0) ? 8'(8'h80 + k) : COM, acc);
            if (acc) nd++;
        end

        // Two-cycle dropout is tolerated.
        act_cycle(1'b0, 8'h00, 1'b0, 8'h00, acc);
        act_cycle(1'b0, 8'h00, 1'b0, 8'h00, acc);
        act_cycle(1'b0, 8'h00, 1'b1, IDL, acc);

        // Three-cycle dropout: offered payload on the loss edge is not taken.
        act_cycle(1'b0, 8'h00, 1'b0, 8'h00, acc);
        act_cycle(1'b0, 8'h00, 1'b0, 8'h00, acc);
        valid_in      = 1'b1;
        data_in       = 8'hD7;
        rx_byte_valid = 1'b0;
        chk("loss_ready", ready_out, 1);
        cyc();
        chk("loss_active", active, 0);
        chk("loss_tx", tx_byte, COM);
        chk("loss_idle", idle_out, 0);
        chk("loss_valid_out", valid_out, 0);

        // Loss landing on the COM-insertion cycle returns to TRAIN.
        lock4();
        for (int k = 0; k < 13; k++) act_cycle(1'b0, 8'h00, 1'b1, IDL, acc);
        act_cycle(1'b0, 8'h00, 1'b0, 8'h00, acc);
        act_cycle(1'b0, 8'h00, 1'b0, 8'h00, acc);
        valid_in      = 1'b0;
        rx_byte_valid = 1'b0;
        chk("skiploss_ready", ready_out, 0);
        cyc();
        chk("skiploss_active", active, 0);
        chk("skiploss_tx", tx_byte, COM);

        // Reset while streaming.
        lock4();
        nd = 8'h50;
        for (int k = 0; k < 5; k++) begin
            act_cycle(1'b1, nd, 1'b1, 8'(8'h30 + k), acc);
            if (acc) nd++;
        end
        reset         = 1'b1;
        valid_in      = 1'b1;
        data_in       = 8'h99;
        rx_byte_valid = 1'b1;
        rx_byte       = 8'h66;
        #1;
        chk("midrst_ready", ready_out, 0);
        cyc();
        chk("midrst_tx", tx_byte, 8'h00);
        chk("midrst_active", active, 0);
        chk("midrst_idle", idle_out, 0);
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_err", err_out, 0);
        chk("midrst_data_out", data_out, 8'h00);
        reset         = 1'b0;
        valid_in      = 1'b0;
        rx_byte_valid = 1'b0;
        cyc();
        chk("post_rst_tx", tx_byte, COM);
        chk("post_rst_active", active, 0);

        // Retrain and confirm the insertion period restarts from zero.
        lock4();
        nd = 8'h60;
        for (int k = 0; k < 18; k++) begin
            act_cycle(1'b1, nd, 1'b1, IDL, acc);
            if (acc) nd++;
        end

        valid_in = 1'b0;
        cyc();
        cyc();
        chk("tx_q_drained", tx_q.size(), 0);
        chk("rx_q_drained", rx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/link_sync_ctrl.md
# link_sync_ctrl

Byte-rate link controller that sequences the paralelo-serial TX and serial-paralelo RX pair of the physical layer. It runs link training by sending COM symbols until the RX side reports N_LOCK consecutive COMs. It then passes upstream payload to the TX, inserting IDL when there is no payload and a periodic COM for alignment. It also filters received bytes and drops back to training on loss of sync.

## Interface
- COM, 8'hBC: comma/alignment symbol.
- IDL, 8'h7C: idle symbol.
- N_LOCK, 4: consecutive valid COMs received to declare lock (≥1).
- N_LOSS, 3: consecutive cycles without rx_byte_valid to declare loss (≥1).
- SKIP_PERIOD, 16: ACTIVE cycles per inserted COM (≥2).

- clk_4f  in  1  byte clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- rx_byte  in  8  byte from serial-paralelo RX.
- rx_byte_valid  in  1  RX aligned, rx_byte meaningful this cycle.
- data_in  in  8  upstream payload byte.
- valid_in  in  1  data_in offered.
- ready_out  out  1  payload accepted this cycle when valid_in && ready_out.
- tx_byte  out  8  byte to paralelo-serial TX.
- active  out  1  link locked (state ACTIVE).
- idle_out  out  1  tx_byte currently carries IDL.
- data_out  out  8  received payload byte.
- valid_out  out  1  data_out valid (1-cycle pulse per byte).
- err_out  out  1  1-cycle pulse: upstream offered COM or IDL as payload.

## Operation
- States: TRAIN, ACTIVE. Counters: lock_cnt (0..N_LOCK), loss_cnt (0..N_LOSS), skip_cnt (0..SKIP_PERIOD-1). Each counter is ceil(log2(max+1)) bits wide and saturating.
- Reset values: state TRAIN, all counters 0, tx_byte 8'h00, active 0, idle_out 0, data_out 8'h00, valid_out 0, err_out 0.
- ready_out is combinational: active && (skip_cnt != SKIP_PERIOD-1). It is 0 during reset.
- TRAIN:
  - tx_byte<=COM, idle_out<=0, valid_out<=0.
  - lock_cnt<=lock_cnt+1 when rx_byte_valid && rx_byte==COM; otherwise lock_cnt<=0.
  - When the incoming COM makes the count reach N_LOCK: state<=ACTIVE, active<=1, lock_cnt, loss_cnt and skip_cnt<=0, all on the same edge.
- ACTIVE, TX side:
  - If skip_cnt==SKIP_PERIOD-1: tx_byte<=COM, idle_out<=0, skip_cnt<=0. No payload is accepted that cycle.
  - Else if valid_in and data_in is neither COM nor IDL: tx_byte<=data_in, idle_out<=0.
  - Else if valid_in and data_in is COM or IDL: the byte is consumed, tx_byte<=IDL, idle_out<=1, err_out<=1.
  - Else: tx_byte<=IDL, idle_out<=1.
  - skip_cnt increments every ACTIVE cycle except the insertion cycle.
- ACTIVE, RX side:
  - rx_byte_valid with rx_byte not COM and not IDL: data_out<=rx_byte, valid_out<=1. Otherwise valid_out<=0 and data_out holds.
  - rx_byte_valid=1 clears loss_cnt; rx_byte_valid=0 increments it.
  - When loss_cnt would reach N_LOSS: state<=TRAIN, active<=0, all counters<=0, tx_byte<=COM.
- Simultaneous events: loss has priority over skip insertion and payload. On the loss edge, payload is not accepted even though ready_out was 1, so upstream must re-offer. valid_out<=0 on the loss edge.
- Reset mid-operation: on the next edge all state and outputs take their reset values, regardless of state. Any in-flight payload is dropped.

## Timing
- TX latency: a payload accepted at edge k appears on tx_byte after edge k, i.e. one cycle.
- RX latency: rx_byte sampled at edge k appears on data_out/valid_out after edge k.
- Lock: with COM on rx in cycles c1..cN_LOCK, active rises at the edge ending cN_LOCK. ready_out is 1 in the following cycle. tx_byte is still COM in the first ACTIVE cycle.
- Skip: first inserted COM after lock is driven by the edge ending ACTIVE cycle SKIP_PERIOD. ready_out is 0 during that cycle.
- Loss: active falls at the edge ending the N_LOSS-th consecutive invalid cycle.
- First TX byte after reset is COM, driven by the first non-reset edge.

## Test plan
- Reset: hold reset 2 cycles → tx_byte=00, active=0, ready_out=0, valid_out=0, err_out=0. One cycle after release → tx_byte=BC.
- Lock: rx_byte=BC with valid for 4 cycles → active=1 at the 4th edge, ready_out=1 the next cycle. Variant BC,BC,BC,55,BC×4 → lock only after the final 4 BCs.
- Payload/idle: after lock, offer A5, 3C, then no valid → tx_byte=A5, 3C, then 7C with idle_out=1. rx 12 then 7C → data_out=12 with valid_out pulse, then valid_out=0.
- Skip and errors: continuous valid_in after lock → tx_byte=BC and ready_out=0 every 16th ACTIVE cycle, with no payload lost. Offer BC as payload → tx_byte=7C and err_out pulses once.
- Loss: drop rx_byte_valid for 2 cycles then restore → stays active. Drop for 3 cycles → active=0 and tx_byte=BC on the 3rd edge. Loss coinciding with skip cycle → TRAIN wins.
- Reset mid-ACTIVE while streaming payload → all outputs at reset values next edge, and link retrains from TRAIN.
